// File: rtl/branch_stats_tracker.sv
// Multi-port branch prediction statistics with streak tracking, sticky overflow and a registered read port.
// Updates land on the next edge; read data appears one cycle after rd_req. No backpressure: every update and read is accepted.
module branch_stats_tracker #(
   parameter int NUM_PORTS = 2,
   parameter int CNT_WIDTH = 32,
   parameter int SATURATE  = 1
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic [NUM_PORTS-1:0] update_predictor,
   input  logic [NUM_PORTS-1:0] prediction,
   input  logic [NUM_PORTS-1:0] branch_result,
   input  logic                 freeze,
   input  logic                 clear,
   input  logic                 rd_req,
   input  logic [2:0]           rd_sel,
   output logic                 rd_valid,
   output logic [CNT_WIDTH-1:0] rd_data,
   output logic                 overflow
);

   localparam int IW = $clog2(NUM_PORTS + 1);

   // Index 7 is max_streak; 0..6 follow the rd_sel encoding.
   localparam int C_PRED = 0;
   localparam int C_MISP = 1;
   localparam int C_CORR = 2;
   localparam int C_PTKN = 3;
   localparam int C_PNTK = 4;
   localparam int C_TINC = 5;
   localparam int C_NINC = 6;
   localparam int C_MAXS = 7;

   logic [CNT_WIDTH-1:0] cnt_q [8];
   logic [CNT_WIDTH-1:0] cnt_d [8];
   logic [CNT_WIDTH-1:0] cur_streak_q, cur_streak_d;
   logic                 overflow_q, overflow_d;
   logic                 rd_valid_q, rd_valid_d;
   logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;

   logic [IW-1:0]        inc     [7];
   logic [CNT_WIDTH:0]   sum     [7];
   logic [CNT_WIDTH-1:0] upd_val [7];
   logic [CNT_WIDTH-1:0] cur_s, max_s;
   logic                 streak_ovf, ovf_any, misp;

   always_comb begin
      for (int k = 0; k < 7; k++) inc[k] = '0;
      cur_s      = cur_streak_q;
      max_s      = cnt_q[C_MAXS];
      streak_ovf = 1'b0;
      misp       = 1'b0;

      // Walk ports oldest-first so the streak peak inside a cycle is captured.
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (update_predictor[i]) begin
            misp = prediction[i] != branch_result[i];
            inc[C_PRED] = inc[C_PRED] + IW'(1);
            if (prediction[i]) inc[C_PTKN] = inc[C_PTKN] + IW'(1);
            else               inc[C_PNTK] = inc[C_PNTK] + IW'(1);
            if (misp) begin
               inc[C_MISP] = inc[C_MISP] + IW'(1);
               if (prediction[i]) inc[C_TINC] = inc[C_TINC] + IW'(1);
               else               inc[C_NINC] = inc[C_NINC] + IW'(1);
               if (&cur_s) streak_ovf = 1'b1;
               else        cur_s = cur_s + CNT_WIDTH'(1);
               if (cur_s > max_s) max_s = cur_s;
            end else begin
               inc[C_CORR] = inc[C_CORR] + IW'(1);
               cur_s = '0;
            end
         end
      end

      ovf_any = streak_ovf;
      for (int k = 0; k < 7; k++) begin
         sum[k]     = {1'b0, cnt_q[k]} + {{(CNT_WIDTH + 1 - IW){1'b0}}, inc[k]};
         ovf_any    = ovf_any | sum[k][CNT_WIDTH];
         upd_val[k] = (sum[k][CNT_WIDTH] && (SATURATE != 0)) ? '1 : sum[k][CNT_WIDTH-1:0];
      end

      for (int k = 0; k < 8; k++) cnt_d[k] = cnt_q[k];
      cur_streak_d = cur_streak_q;
      overflow_d   = overflow_q;
      if (clear) begin
         for (int k = 0; k < 8; k++) cnt_d[k] = '0;
         cur_streak_d = '0;
         overflow_d   = 1'b0;
      end else if (!freeze) begin
         for (int k = 0; k < 7; k++) cnt_d[k] = upd_val[k];
         cnt_d[C_MAXS] = max_s;
         cur_streak_d  = cur_s;
         overflow_d    = overflow_q | ovf_any;
      end

      // Reads sample the registered state, so they see pre-update / pre-clear values.
      rd_valid_d = rd_req;
      rd_data_d  = rd_req ? cnt_q[rd_sel] : rd_data_q;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int k = 0; k < 8; k++) cnt_q[k] <= '0;
         cur_streak_q <= '0;
         overflow_q   <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_data_q    <= '0;
      end else begin
         for (int k = 0; k < 8; k++) cnt_q[k] <= cnt_d[k];
         cur_streak_q <= cur_streak_d;
         overflow_q   <= overflow_d;
         rd_valid_q   <= rd_valid_d;
         rd_data_q    <= rd_data_d;
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_branch_stats_tracker.sv
// Bench for branch_stats_tracker: a 32-bit instance checked through a read scoreboard,
// plus two 8-bit instances (saturating and wrapping) sharing the same stimulus.
module tb_branch_stats_tracker;

   logic        CLK = 1'b0;
   logic        nRST;
   logic [1:0]  upd, pred, res;
   logic        freeze, clear, rd_req;
   logic [2:0]  rd_sel;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        overflow;
   logic        rv8s, rv8w, ov8s, ov8w;
   logic [7:0]  rd8s, rd8w;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];
   longint m_cnt[8];
   longint m_cur;

   always #5 CLK = ~CLK;

   branch_stats_tracker #(.NUM_PORTS(2), .CNT_WIDTH(32), .SATURATE(1)) dut (
      .CLK(CLK), .nRST(nRST), .update_predictor(upd), .prediction(pred), .branch_result(res),
      .freeze(freeze), .clear(clear), .rd_req(rd_req), .rd_sel(rd_sel),
      .rd_valid(rd_valid), .rd_data(rd_data), .overflow(overflow));

   branch_stats_tracker #(.NUM_PORTS(2), .CNT_WIDTH(8), .SATURATE(1)) dut8s (
      .CLK(CLK), .nRST(nRST), .update_predictor(upd), .prediction(pred), .branch_result(res),
      .freeze(freeze), .clear(clear), .rd_req(rd_req), .rd_sel(rd_sel),
      .rd_valid(rv8s), .rd_data(rd8s), .overflow(ov8s));

   branch_stats_tracker #(.NUM_PORTS(2), .CNT_WIDTH(8), .SATURATE(0)) dut8w (
      .CLK(CLK), .nRST(nRST), .update_predictor(upd), .prediction(pred), .branch_result(res),
      .freeze(freeze), .clear(clear), .rd_req(rd_req), .rd_sel(rd_sel),
      .rd_valid(rv8w), .rd_data(rd8w), .overflow(ov8w));

   task automatic model_zero();
      for (int k = 0; k < 8; k++) m_cnt[k] = 0;
      m_cur = 0;
   endtask

   // One clock: inputs captured before the edge, the read scoreboard is drained after it,
   // and the reference model advances with the captured inputs.
   task automatic tick();
      logic       req, f, c;
      logic [1:0] u, p, r;
      logic [31:0] e;
      req = rd_req; u = upd; p = pred; r = res; f = freeze; c = clear;
      @(posedge CLK);
      #1;
      checks++;
      if (req) begin
         if (rd_valid !== 1'b1) $display("FAIL rd_valid_after_req: got %b expected 1", rd_valid);
         if (rd_valid !== 1'b1) errors++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got response, expected none queued");
         end else begin
            e = exp_q.pop_front();
            if (rd_data !== e) begin
               errors++;
               $display("FAIL rd_data: got %0d expected %0d", rd_data, e);
            end
         end
      end else if (rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL rd_valid_idle: got %b expected 0", rd_valid);
      end
      if (c) model_zero();
      else if (!f) begin
         for (int i = 0; i < 2; i++) begin
            if (u[i]) begin
               m_cnt[0]++;
               if (p[i]) m_cnt[3]++; else m_cnt[4]++;
               if (p[i] != r[i]) begin
                  m_cnt[1]++;
                  if (p[i]) m_cnt[5]++; else m_cnt[6]++;
                  m_cur++;
                  if (m_cur > m_cnt[7]) m_cnt[7] = m_cur;
               end else begin
                  m_cnt[2]++;
                  m_cur = 0;
               end
            end
         end
      end
   endtask

   task automatic do_read(input logic [2:0] sel, input logic [31:0] exp);
      rd_req = 1'b1;
      rd_sel = sel;
      exp_q.push_back(exp);
      tick();
      rd_req = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      nRST = 1'b0; upd = '0; pred = '0; res = '0;
      freeze = 1'b0; clear = 1'b0; rd_req = 1'b0; rd_sel = '0;
      model_zero();
      #12;
      checks++;
      if (rd_valid !== 1'b0 || rd_data !== 32'd0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b d=%0d o=%b expected 0/0/0", rd_valid, rd_data, overflow);
      end
      @(negedge CLK) nRST = 1'b1;
      for (int s = 0; s < 8; s++) do_read(3'(s), 32'd0);
   endtask

   task automatic test_basic();
      upd = 2'b11; pred = 2'b10; res = 2'b00;
      tick();
      upd = '0;
      do_read(3'd0, 32'd2);
      do_read(3'd1, 32'd1);
      do_read(3'd2, 32'd1);
      do_read(3'd5, 32'd1);
      tick();
   endtask

   task automatic test_streak();
      pulse_clear();
      upd = 2'b11; pred = 2'b00; res = 2'b11;
      repeat (5) tick();
      res = 2'b10;
      tick();
      upd = '0;
      do_read(3'd7, 32'd10);
      do_read(3'd1, 32'd11);
      // cur_streak is 1 here, so ten more mispredicts lift the peak to 11.
      upd = 2'b11; res = 2'b11;
      repeat (5) tick();
      upd = '0;
      do_read(3'd7, 32'd11);
      do_read(3'd1, 32'd21);
      do_read(3'd6, 32'd21);
   endtask

   task automatic test_read_during_update();
      longint old;
      old = m_cnt[0];
      upd = 2'b11; pred = 2'b11; res = 2'b11;
      do_read(3'd0, 32'(old));
      upd = '0;
      do_read(3'd0, 32'(old + 2));
      do_read(3'd3, 32'(m_cnt[3]));
   endtask

   task automatic test_saturate();
      pulse_clear();
      upd = 2'b11; pred = 2'b00; res = 2'b00;
      repeat (130) tick();
      upd = '0;
      do_read(3'd0, 32'd260);
      checks++;
      if (rv8s !== 1'b1 || rd8s !== 8'd255) begin
         errors++;
         $display("FAIL sat8_predictions: got v=%b d=%0d expected 1/255", rv8s, rd8s);
      end
      checks++;
      if (rv8w !== 1'b1 || rd8w !== 8'd4) begin
         errors++;
         $display("FAIL wrap8_predictions: got v=%b d=%0d expected 1/4", rv8w, rd8w);
      end
      checks++;
      if (ov8s !== 1'b1 || ov8w !== 1'b1 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL overflow_flags: got s=%b w=%b main=%b expected 1/1/0", ov8s, ov8w, overflow);
      end
      do_read(3'd4, 32'd260);
      do_read(3'd1, 32'd0);
   endtask

   task automatic test_freeze_clear();
      freeze = 1'b1;
      upd = 2'b11; pred = 2'b01; res = 2'b10;
      repeat (10) tick();
      upd = '0;
      for (int s = 0; s < 8; s++) do_read(3'(s), 32'(m_cnt[s]));
      do_read(3'd0, 32'd260);
      checks++;
      if (rd8s !== 8'd255 || ov8s !== 1'b1) begin
         errors++;
         $display("FAIL freeze_hold8: got d=%0d o=%b expected 255/1", rd8s, ov8s);
      end
      pulse_clear();
      freeze = 1'b0;
      checks++;
      if (ov8s !== 1'b0 || ov8w !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL clear_overflow: got s=%b w=%b main=%b expected 0/0/0", ov8s, ov8w, overflow);
      end
      for (int s = 0; s < 8; s++) do_read(3'(s), 32'd0);
   endtask

   task automatic test_async_reset();
      test_saturate();
      rd_req = 1'b1; rd_sel = 3'd0;
      exp_q.push_back(32'd260);
      tick();
      rd_req = 1'b0;
      #3 nRST = 1'b0;
      #1;
      checks++;
      if (rd_valid !== 1'b0 || rd_data !== 32'd0 || overflow !== 1'b0 || ov8s !== 1'b0 || rd8s !== 8'd0) begin
         errors++;
         $display("FAIL async_reset_now: got v=%b d=%0d o=%b o8=%b d8=%0d expected all 0",
                  rd_valid, rd_data, overflow, ov8s, rd8s);
      end
      @(posedge CLK);
      #1;
      checks++;
      if (rd_valid !== 1'b0 || rd_data !== 32'd0 || ov8w !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_held: got v=%b d=%0d o8w=%b expected 0", rd_valid, rd_data, ov8w);
      end
      @(negedge CLK) nRST = 1'b1;
      model_zero();
      for (int s = 0; s < 8; s++) do_read(3'(s), 32'd0);
      checks++;
      if (ov8s !== 1'b0 || rd8s !== 8'd0) begin
         errors++;
         $display("FAIL async_reset_after: got o8=%b d8=%0d expected 0/0", ov8s, rd8s);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_streak();
      test_read_during_update();
      test_saturate();
      test_freeze_clear();
      test_async_reset();
      tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
